argon_mem_arbiter: RTL and testbench



---
 rtl/argon_mem_pkg.sv | 27 ++
 rtl/argon_arb_pick.sv | 24 ++
 rtl/argon_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_argon_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/argon_mem_pkg.sv
// rtl/argon_mem_pkg.sv - shared mask encodings, arbiter state and requester ids for the memory arbiter.
package argon_mem_pkg;

  localparam logic [2:0] RDMASK_NONE = 3'd0;
  localparam logic [2:0] RDMASK_B    = 3'd1;
  localparam logic [2:0] RDMASK_BU   = 3'd2;
  localparam logic [2:0] RDMASK_H    = 3'd3;
  localparam logic [2:0] RDMASK_HU   = 3'd4;
  localparam logic [2:0] RDMASK_W    = 3'd5;

  localparam logic [1:0] WRMASK_NONE = 2'd0;
  localparam logic [1:0] WRMASK_B    = 2'd1;
  localparam logic [1:0] WRMASK_H    = 2'd2;
  localparam logic [1:0] WRMASK_W    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage

// File: rtl/argon_arb_pick.sv
// rtl/argon_arb_pick.sv - combinational winner select; ARGON_MEM_ARB_RR_EN gives round-robin, else D over IF.
module argon_arb_pick
  import argon_mem_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
`ifdef ARGON_MEM_ARB_RR_EN
  input  req_id_t arb_ptr,
`endif
  output req_id_t winner
);

  always_comb begin
    winner = REQ_D;
`ifdef ARGON_MEM_ARB_RR_EN
    // arb_ptr names the requester that wins the next conflict
    if (if_req && d_req) winner = arb_ptr;
    else if (if_req)     winner = REQ_IF;
`else
    if (if_req && !d_req) winner = REQ_IF;
`endif
  end

endmodule

// File: rtl/argon_mem_arbiter.sv
// rtl/argon_mem_arbiter.sv - one-outstanding arbiter sharing the 32-bit memory port between fetch and load/store.
// Define ARGON_MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-IF priority.
module argon_mem_arbiter
  import argon_mem_pkg::*;
#(
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_rd_mask,
  input  logic [1:0]  i_d_wr_mask,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [2:0]  o_mem_rd_mask,
  output logic [1:0]  o_mem_wr_mask,
  input  logic [31:0] i_mem_rd_data,
  output logic        o_busy
);

  localparam int               CNT_W    = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  arb_state_t       state, state_nxt;
  req_id_t          winner, owner;
  logic             is_store, capture, any_req;
  logic [CNT_W-1:0] cnt;

  assign any_req = i_if_req | i_d_req;
  assign o_busy  = (state != IDLE);

`ifdef ARGON_MEM_ARB_RR_EN
  req_id_t arb_ptr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                arb_ptr <= REQ_D;
    else if (state == IDLE && any_req) arb_ptr <= (winner == REQ_D) ? REQ_IF : REQ_D;
  end

  argon_arb_pick u_pick (.if_req(i_if_req), .d_req(i_d_req), .arb_ptr(arb_ptr), .winner(winner));
`else
  argon_arb_pick u_pick (.if_req(i_if_req), .d_req(i_d_req), .winner(winner));
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (is_store) state_nxt = IDLE;
        else if (RD_LATENCY > 1) state_nxt = WAIT;
        else begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      owner         <= REQ_D;
      is_store      <= 1'b0;
      cnt           <= '0;
      o_if_gnt      <= 1'b0;
      o_d_gnt       <= 1'b0;
      o_if_rvalid   <= 1'b0;
      o_d_rvalid    <= 1'b0;
      o_if_rdata    <= '0;
      o_d_rdata     <= '0;
      o_mem_addr    <= RESET_ADDR;
      o_mem_wr_data <= '0;
      o_mem_rd_mask <= RDMASK_NONE;
      o_mem_wr_mask <= WRMASK_NONE;
    end else begin
      state       <= state_nxt;
      o_if_gnt    <= 1'b0;
      o_d_gnt     <= 1'b0;
      o_if_rvalid <= capture && (owner == REQ_IF);
      o_d_rvalid  <= capture && (owner == REQ_D);
      if (capture && owner == REQ_IF) o_if_rdata <= i_mem_rd_data;
      if (capture && owner == REQ_D)  o_d_rdata  <= i_mem_rd_data;

      case (state)
        IDLE: begin
          // transaction is latched here so the bus is stable for the whole ISSUE cycle
          if (any_req) begin
            owner <= winner;
            if (winner == REQ_D) begin
              o_d_gnt       <= 1'b1;
              o_mem_addr    <= i_d_addr;
              o_mem_wr_data <= i_d_wdata;
              is_store      <= i_d_we;
              o_mem_rd_mask <= i_d_we ? RDMASK_NONE : i_d_rd_mask;
              o_mem_wr_mask <= i_d_we ? i_d_wr_mask : WRMASK_NONE;
            end else begin
              o_if_gnt      <= 1'b1;
              o_mem_addr    <= i_if_addr;
              is_store      <= 1'b0;
              o_mem_rd_mask <= RDMASK_W;
              o_mem_wr_mask <= WRMASK_NONE;
            end
          end
        end
        ISSUE:   cnt <= CNT_LOAD;
        WAIT:    cnt <= cnt - CNT_W'(1);
        default: cnt <= '0;
      endcase

      if (state != IDLE && state_nxt == IDLE) begin
        o_mem_rd_mask <= RDMASK_NONE;
        o_mem_wr_mask <= WRMASK_NONE;
      end
    end
  end

endmodule

// File: tb/tb_argon_mem_arbiter.sv
// tb/tb_argon_mem_arbiter.sv - directed scoreboard bench over three arbiters with RD_LATENCY 1, 2 and 4.
module tb_argon_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req      [3];
  logic [31:0] if_addr     [3];
  logic        if_gnt      [3];
  logic        if_rvalid   [3];
  logic [31:0] if_rdata    [3];
  logic        d_req       [3];
  logic        d_we        [3];
  logic [31:0] d_addr      [3];
  logic [31:0] d_wdata     [3];
  logic [2:0]  d_rd_mask   [3];
  logic [1:0]  d_wr_mask   [3];
  logic        d_gnt       [3];
  logic        d_rvalid    [3];
  logic [31:0] d_rdata     [3];
  logic [31:0] mem_addr    [3];
  logic [31:0] mem_wr_data [3];
  logic [2:0]  mem_rd_mask [3];
  logic [1:0]  mem_wr_mask [3];
  logic [31:0] mem_rd_data [3];
  logic        busy        [3];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  logic [31:0] sb [$];
  logic [31:0] model_if_rdata [3];
  logic [31:0] model_d_rdata  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) + 32'h1234;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mem_rd_data[g] = mem_model(mem_addr[g]);
    argon_mem_arbiter #(
      .RD_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
      .RESET_ADDR((g == 0) ? 32'h0000_0F00 : 32'h0)
    ) u_dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_if_req(if_req[g]), .i_if_addr(if_addr[g]), .o_if_gnt(if_gnt[g]),
      .o_if_rvalid(if_rvalid[g]), .o_if_rdata(if_rdata[g]),
      .i_d_req(d_req[g]), .i_d_we(d_we[g]), .i_d_addr(d_addr[g]), .i_d_wdata(d_wdata[g]),
      .i_d_rd_mask(d_rd_mask[g]), .i_d_wr_mask(d_wr_mask[g]), .o_d_gnt(d_gnt[g]),
      .o_d_rvalid(d_rvalid[g]), .o_d_rdata(d_rdata[g]),
      .o_mem_addr(mem_addr[g]), .o_mem_wr_data(mem_wr_data[g]),
      .o_mem_rd_mask(mem_rd_mask[g]), .o_mem_wr_mask(mem_wr_mask[g]),
      .i_mem_rd_data(mem_rd_data[g]), .o_busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one transaction on instance k: drive, wait for grant, check bus, then completion
  task automatic txn(input int k, input bit use_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] rm, input logic [1:0] wm);
    int          n;
    int          exp_n;
    bit          rv;
    logic [31:0] exp_data;
    logic [2:0]  exp_rm;
    logic [1:0]  exp_wm;
    exp_rm = use_d ? (we ? 3'd0 : rm) : 3'd5;
    exp_wm = (use_d && we) ? wm : 2'd0;
    if (use_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr;
      d_wdata[k] = wdata; d_rd_mask[k] = rm; d_wr_mask[k] = wm;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    if (!(use_d && we)) sb.push_back(mem_model(addr));
    n = 0;
    do begin @(negedge clk); n++; end while (!(use_d ? d_gnt[k] : if_gnt[k]) && n < 50);
    chk($sformatf("gnt_latency[%0d]", k), n, 1);
    last_gnt_cyc = cyc;
    chk($sformatf("gnt_addr[%0d]", k), mem_addr[k], addr);
    chk($sformatf("gnt_rd_mask[%0d]", k), mem_rd_mask[k], exp_rm);
    chk($sformatf("gnt_wr_mask[%0d]", k), mem_wr_mask[k], exp_wm);
    chk($sformatf("gnt_busy[%0d]", k), busy[k], 1);
    if (use_d) chk($sformatf("gnt_wr_data[%0d]", k), mem_wr_data[k], wdata);
    if (use_d) d_req[k] = 1'b0;
    else       if_req[k] = 1'b0;
    if (use_d && we) begin
      @(negedge clk);
      chk($sformatf("store_no_rvalid[%0d]", k), d_rvalid[k], 0);
      chk($sformatf("store_idle[%0d]", k), busy[k], 0);
      chk($sformatf("store_wr_mask_off[%0d]", k), mem_wr_mask[k], 0);
    end else begin
      exp_n = (lat(k) == 1) ? 1 : lat(k) + 1;
      n = 0;
      do begin
        @(negedge clk); n++;
        rv = use_d ? d_rvalid[k] : if_rvalid[k];
        if (!rv) begin
          chk($sformatf("rdata_hold[%0d]", k), use_d ? d_rdata[k] : if_rdata[k],
              use_d ? model_d_rdata[k] : model_if_rdata[k]);
          chk($sformatf("wait_busy[%0d]", k), busy[k], 1);
          chk($sformatf("wait_rd_mask[%0d]", k), mem_rd_mask[k], exp_rm);
          chk($sformatf("wait_addr[%0d]", k), mem_addr[k], addr);
        end
      end while (!rv && n < 20);
      chk($sformatf("rvalid_after_gnt[%0d]", k), n, exp_n);
      exp_data = (sb.size() > 0) ? sb.pop_front() : 32'hX;
      chk($sformatf("rdata[%0d]", k), use_d ? d_rdata[k] : if_rdata[k], exp_data);
      if (use_d) model_d_rdata[k] = exp_data;
      else       model_if_rdata[k] = exp_data;
      chk($sformatf("done_rd_mask[%0d]", k), mem_rd_mask[k], 0);
      chk($sformatf("done_busy[%0d]", k), busy[k], 0);
    end
  endtask

  initial begin
    int          n;
    int          g1;
    int          if_left;
    int          d_left;
    logic [3:0]  order;
    logic [3:0]  exp_order;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0;
      d_wdata[k] = '0; d_rd_mask[k] = '0; d_wr_mask[k] = '0;
      model_if_rdata[k] = '0; model_d_rdata[k] = '0;
    end
    #12;
    chk("rst_mem_addr0", mem_addr[0], 32'h0000_0F00);
    chk("rst_mem_addr1", mem_addr[1], 32'h0);
    chk("rst_wr_data", mem_wr_data[0], 0);
    chk("rst_masks", {mem_rd_mask[0], mem_wr_mask[0]}, 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_gnt_rvalid", {if_gnt[0], d_gnt[0], if_rvalid[0], d_rvalid[0]}, 0);
    chk("rst_rdata", if_rdata[0] | d_rdata[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RD_LATENCY=1 fetch, then word store and a no-effect store
    txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 3'd0, 2'd0);
    txn(0, 1'b1, 1'b1, 32'h2000, 32'h12345678, 3'd0, 2'd3);
    txn(0, 1'b1, 1'b1, 32'h2004, 32'hCAFE0001, 3'd0, 2'd0);

    // RD_LATENCY=2 back-to-back fetches
    txn(1, 1'b0, 1'b0, 32'h300, 32'h0, 3'd0, 2'd0);
    g1 = last_gnt_cyc;
    txn(1, 1'b0, 1'b0, 32'h304, 32'h0, 3'd0, 2'd0);
    chk("b2b_gnt_spacing", last_gnt_cyc - g1, 4);

    // RD_LATENCY=4 halfword-unsigned load
    txn(2, 1'b1, 1'b0, 32'h30, 32'h0, 3'd4, 2'd0);

    // reset during WAIT
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h44; d_rd_mask[2] = 3'd5;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt[2] && n < 50);
    chk("abort_gnt_latency", n, 1);
    d_req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy[2], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_async", busy[2], 0);
    chk("abort_rd_mask_async", mem_rd_mask[2], 0);
    chk("abort_addr_async", mem_addr[2], 32'h0);
    for (int k = 0; k < 3; k++) begin
      model_if_rdata[k] = '0; model_d_rdata[k] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_rvalid[2] || if_rvalid[2]) n++;
    end
    chk("abort_no_rvalid", n, 0);
    txn(2, 1'b0, 1'b0, 32'h200, 32'h0, 3'd0, 2'd0);

    // arbitration: both requesters want two transactions, starting right after reset
`ifdef ARGON_MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1100;
`endif
    if_addr[0] = 32'h80; if_req[0] = 1'b1;
    d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h5A5A; d_wr_mask[0] = 2'd3; d_req[0] = 1'b1;
    if_left = 2; d_left = 2; order = '0; n = 0;
    while ((if_left > 0 || d_left > 0) && n < 60) begin
      @(negedge clk); n++;
      if (d_gnt[0]) begin
        order = {order[2:0], 1'b1}; d_left--;
        if (d_left == 0) d_req[0] = 1'b0;
      end
      if (if_gnt[0]) begin
        order = {order[2:0], 1'b0}; if_left--;
        if (if_left == 0) if_req[0] = 1'b0;
      end
    end
    chk("arb_grant_order", order, exp_order);
    chk("arb_grant_count", if_left + d_left, 0);
    repeat (3) @(negedge clk);
    chk("arb_final_idle", busy[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
